// File: rtl/rom_loader.sv
// Boot loader: assembles big-endian 16-bit words from a UART byte stream into the
// instruction ROM and releases CPU reset once a checksum-valid frame has loaded.
module rom_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int ROM_DEPTH      = 4096,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [15:0]           rom_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_WORD_HI,
        S_WORD_LO,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_sum;
    logic [7:0]            r_cnt_hi;
    logic [7:0]            r_hi;
    logic [ADDR_WIDTH:0]   r_n;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [ADDR_WIDTH:0]   w_idx_inc;
    logic [TW-1:0]         r_tmo;
    logic [31:0]           w_n32;
    logic                  w_timing;
    logic                  w_expire;
    logic                  w_write;
    logic                  w_ok;
    logic                  w_fail;

    assign w_n32     = {16'd0, r_cnt_hi, rx_data};
    assign w_idx_inc = r_idx + (ADDR_WIDTH+1)'(1);
    assign w_timing  = r_state inside {S_CNT_LO, S_WORD_HI, S_WORD_LO, S_CHK};
    // An arriving byte on the expiry cycle takes priority over the timeout.
    assign w_expire  = w_timing && !rx_valid && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_ok        = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            S_CNT_HI: if (rx_valid) w_state_nxt = S_CNT_LO;
            S_CNT_LO: begin
                if (rx_valid) begin
                    if (w_n32 > 32'(ROM_DEPTH)) begin
                        w_state_nxt = S_ERROR;
                        w_fail      = 1'b1;
                    end else if (w_n32 == '0) begin
                        w_state_nxt = S_CHK;
                    end else begin
                        w_state_nxt = S_WORD_HI;
                    end
                end
            end
            S_WORD_HI: if (rx_valid) w_state_nxt = S_WORD_LO;
            S_WORD_LO: begin
                if (rx_valid) begin
                    w_write     = 1'b1;
                    w_state_nxt = (w_idx_inc == r_n) ? S_CHK : S_WORD_HI;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == r_sum) begin
                        w_state_nxt = S_DONE;
                        w_ok        = 1'b1;
                    end else begin
                        w_state_nxt = S_ERROR;
                        w_fail      = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (w_expire) begin
            w_state_nxt = S_ERROR;
            w_fail      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CNT_HI;
            r_sum     <= '0;
            r_cnt_hi  <= '0;
            r_hi      <= '0;
            r_n       <= '0;
            r_idx     <= '0;
            r_tmo     <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_data  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            rom_we  <= w_write;

            if (rx_valid || !w_timing) r_tmo <= '0;
            else                       r_tmo <= r_tmo + TW'(1);

            if (rx_valid && (r_state inside {S_CNT_HI, S_CNT_LO, S_WORD_HI, S_WORD_LO}))
                r_sum <= r_sum + rx_data;

            if (rx_valid && r_state == S_CNT_HI)  r_cnt_hi <= rx_data;
            if (rx_valid && r_state == S_CNT_LO)  r_n      <= w_n32[ADDR_WIDTH:0];
            if (rx_valid && r_state == S_WORD_HI) r_hi     <= rx_data;

            if (w_write) begin
                rom_addr <= r_idx[ADDR_WIDTH-1:0];
                rom_data <= {r_hi, rx_data};
                if (w_state_nxt == S_WORD_HI) r_idx <= w_idx_inc;
            end

            if (w_ok) begin
                done      <= 1'b1;
                cpu_reset <= 1'b0;
            end
            if (w_fail) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus randomized frames, each
// checked byte-by-byte against a frame-level model of writes, completion and errors.
module tb_rom_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          cpu_reset;
    logic          done;
    logic          error;

    rom_loader #(
        .ADDR_WIDTH    (AW),
        .ROM_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    logic [7:0]    frm[$];
    int            gp[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        m_addr = '0;
        m_data = '0;
        chk("rst_we",   32'(rom_we),    32'd0);
        chk("rst_addr", 32'(rom_addr),  32'd0);
        chk("rst_data", 32'(rom_data),  32'd0);
        chk("rst_cpu",  32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done),      32'd0);
        chk("rst_err",  32'(error),     32'd0);
    endtask

    // gap = number of idle rising edges before the byte is presented
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic add_chk(input logic [7:0] corrupt);
        logic [7:0] s;
        s = '0;
        foreach (frm[i]) s += frm[i];
        frm.push_back(s ^ corrupt);
    endtask

    task automatic zero_gaps();
        gp.delete();
        foreach (frm[i]) gp.push_back(0);
    endtask

    // Frame-level model: N from the first two bytes, words at byte pairs 2..2N+1,
    // checksum byte at 2N+2, inter-byte gap of TMO or more inside a frame is fatal.
    task automatic run_frame();
        int         n;
        int         ci;
        bit         ovf;
        bit         match;
        bit         f_err;
        bit         f_done;
        bit         e_we;
        logic [7:0] s;
        n = 0; ci = 0; ovf = 0; match = 0; f_err = 0; f_done = 0;
        if (frm.size() >= 2) begin
            n   = int'({frm[0], frm[1]});
            ovf = (n > DEPTH);
            ci  = 2 * n + 2;
        end
        s = '0;
        for (int i = 0; i < ci && i < frm.size(); i++) s += frm[i];
        if (!ovf && frm.size() > ci) match = (frm[ci] == s);
        for (int i = 0; i < frm.size(); i++) begin
            if (!f_err && !f_done && i >= 1 && gp[i] >= TMO) f_err = 1;
            send_byte(frm[i], gp[i]);
            e_we = !f_err && !f_done && !ovf && i >= 3 && i <= 2 * n + 1 && (i % 2 == 1);
            if (e_we) begin
                m_addr = AW'((i - 3) / 2);
                m_data = {frm[i-1], frm[i]};
            end
            if (!f_err && !f_done) begin
                if (ovf && i == 1) f_err = 1;
                if (!ovf && i == ci) begin
                    if (match) f_done = 1;
                    else       f_err  = 1;
                end
            end
            chk("we",    32'(rom_we),    32'(e_we));
            chk("addr",  32'(rom_addr),  32'(m_addr));
            chk("data",  32'(rom_data),  32'(m_data));
            chk("done",  32'(done),      32'(f_done));
            chk("error", 32'(error),     32'(f_err));
            chk("cpu",   32'(cpu_reset), 32'(!f_done));
        end
    endtask

    task automatic base_frame();
        frm = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        @(negedge clk);
        do_reset();

        // three-word frame with valid checksum, trailing bytes ignored
        base_frame(); add_chk(8'h00); frm.push_back(8'h12); frm.push_back(8'h34);
        zero_gaps(); run_frame();

        // empty image
        do_reset();
        frm = '{8'h00, 8'h00}; add_chk(8'h00); zero_gaps(); run_frame();

        // bad checksum
        do_reset();
        base_frame(); add_chk(8'h05); frm.push_back(8'h56); frm.push_back(8'h78);
        zero_gaps(); run_frame();

        // count 4097 and DEPTH+1 both exceed the ROM
        do_reset();
        frm = '{8'h10, 8'h01, 8'h12, 8'h34, 8'h56}; zero_gaps(); run_frame();
        do_reset();
        frm = '{8'h00, 8'(DEPTH + 1), 8'h12, 8'h34}; zero_gaps(); run_frame();

        // exactly DEPTH words fills the ROM
        do_reset();
        frm = '{8'h00, 8'(DEPTH)};
        for (int k = 0; k < 2 * DEPTH; k++) frm.push_back(8'($urandom));
        add_chk(8'h00); zero_gaps(); run_frame();

        // timeout onset: error appears exactly after TMO idle cycles
        do_reset();
        frm = '{8'h00, 8'h02, 8'h12}; zero_gaps(); run_frame();
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("tmo_err", 32'(error), 32'(k >= TMO));
        end
        chk("tmo_cpu", 32'(cpu_reset), 32'd1);

        // byte on the expiry cycle is accepted; one cycle later is too late
        do_reset();
        frm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78}; add_chk(8'h00);
        zero_gaps(); gp[3] = TMO - 1; run_frame();
        do_reset();
        frm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78}; add_chk(8'h00);
        zero_gaps(); gp[3] = TMO; run_frame();

        // reset after the first word, then a fresh frame from address 0
        do_reset();
        frm = '{8'h00, 8'h03, 8'h12, 8'h34}; zero_gaps(); run_frame();
        do_reset();
        base_frame(); add_chk(8'h00); zero_gaps(); run_frame();

        // randomized frames
        for (int r = 0; r < 40; r++) begin
            do_reset();
            frm.delete();
            if ($urandom_range(0, 7) == 0) n = $urandom_range(DEPTH + 1, 600);
            else                           n = $urandom_range(0, DEPTH);
            frm.push_back(8'(n >> 8));
            frm.push_back(8'(n));
            if (n <= DEPTH) begin
                for (int k = 0; k < 2 * n; k++) frm.push_back(8'($urandom));
                add_chk(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            end
            for (int k = $urandom_range(0, 2); k > 0; k--) frm.push_back(8'($urandom));
            gp.delete();
            foreach (frm[i])
                gp.push_back(($urandom_range(0, 39) == 0) ? TMO - 1 + int'($urandom_range(0, 1))
                                                          : int'($urandom_range(0, 2)));
            run_frame();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
